// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, waits on imem/dmem ready handshakes with a
// bounded wait, and drives the datapath control set plus per-state enables.
module multicycle_control_fsm #(
  parameter int CMD_WIDTH     = 4,
  parameter int ALU_SEL_WIDTH = 3,
  parameter int MAX_WAIT      = 15,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CMD_WIDTH-1:0]     signalCommand,
  input  logic                     imem_ready,
  input  logic                     dmem_ready,
  input  logic                     stall,
  output logic                     jump,
  output logic                     jr_sel,
  output logic                     jal_sel_d,
  output logic                     jal_sel_addr,
  output logic                     mem_to_reg,
  output logic                     mem_write,
  output logic                     branch,
  output logic                     reg_dest,
  output logic                     alu_src_sel,
  output logic [ALU_SEL_WIDTH-1:0] alu_sel,
  output logic [ALU_SEL_WIDTH-1:0] alui_sel,
  output logic                     pc_write,
  output logic                     ir_write,
  output logic                     reg_write,
  output logic                     imem_read,
  output logic                     dmem_read,
  output logic                     instr_done,
  output logic                     illegal_op,
  output logic                     timeout_err,
  output logic [CNT_WIDTH-1:0]     instr_count,
  output logic [2:0]               state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [CMD_WIDTH-1:0] {
    CMD_LW   = CMD_WIDTH'(0),
    CMD_SW   = CMD_WIDTH'(1),
    CMD_BEQ  = CMD_WIDTH'(2),
    CMD_BNE  = CMD_WIDTH'(3),
    CMD_J    = CMD_WIDTH'(4),
    CMD_JR   = CMD_WIDTH'(5),
    CMD_JAL  = CMD_WIDTH'(6),
    CMD_ADD  = CMD_WIDTH'(7),
    CMD_ADDI = CMD_WIDTH'(8),
    CMD_XORI = CMD_WIDTH'(9),
    CMD_SUB  = CMD_WIDTH'(10),
    CMD_SLT  = CMD_WIDTH'(11)
  } cmd_t;

  localparam logic [ALU_SEL_WIDTH-1:0] ALU_ADD = ALU_SEL_WIDTH'(0);
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SUB = ALU_SEL_WIDTH'(1);
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_XOR = ALU_SEL_WIDTH'(2);
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SLT = ALU_SEL_WIDTH'(3);

  state_t               state_q;
  state_t               state_d;
  cmd_t                 cmd_q;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 illegal_q;
  logic                 timeout_q;

  logic go;
  logic ready_now;
  logic waiting;
  logic wait_hit;
  logic retire;
  logic set_illegal;
  logic set_timeout;
  logic cmd_legal;

  assign go        = reset_n && !stall;
  assign ready_now = (state_q == FETCH) ? imem_ready : dmem_ready;
  assign waiting   = ((state_q == FETCH) || (state_q == MEM)) && !ready_now;
  assign wait_hit  = waiting && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
  assign cmd_legal = (signalCommand <= CMD_WIDTH'(11));

  assign state       = state_q;
  assign illegal_op  = illegal_q;
  assign timeout_err = timeout_q;
  assign instr_count = count_q;
  assign instr_done  = retire;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched command, wait counter, sticky flags and retire counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_q     <= CMD_LW;
      wait_cnt  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == DECODE) && !stall) begin
        cmd_q <= cmd_t'(signalCommand);
      end
      if (!stall) begin
        if ((state_d != state_q) || set_timeout) begin
          wait_cnt <= '0;
        end else if (waiting) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end
      if (retire) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  // Next-state and control decode; stall/reset gating applied last.
  always_comb begin
    state_d      = state_q;
    jump         = 1'b0;
    jr_sel       = 1'b0;
    jal_sel_d    = 1'b0;
    jal_sel_addr = 1'b0;
    mem_to_reg   = 1'b0;
    mem_write    = 1'b0;
    branch       = 1'b0;
    reg_dest     = 1'b0;
    alu_src_sel  = 1'b0;
    alu_sel      = '0;
    alui_sel     = '0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    imem_read    = 1'b0;
    dmem_read    = 1'b0;
    retire       = 1'b0;
    set_illegal  = 1'b0;
    set_timeout  = 1'b0;

    case (state_q)
      FETCH: begin
        imem_read = 1'b1;
        if (wait_hit) begin
          imem_read   = 1'b0;
          set_timeout = 1'b1;
        end else if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end

      DECODE: begin
        if (cmd_legal) begin
          state_d = EXEC;
        end else begin
          set_illegal = 1'b1;
          state_d     = FETCH;
        end
      end

      EXEC: begin
        case (cmd_q)
          CMD_ADD, CMD_SUB, CMD_SLT: begin
            alu_sel  = (cmd_q == CMD_ADD) ? ALU_ADD :
                       (cmd_q == CMD_SUB) ? ALU_SUB : ALU_SLT;
            reg_dest = 1'b1;
            state_d  = WB;
          end
          CMD_ADDI, CMD_XORI: begin
            alui_sel    = (cmd_q == CMD_ADDI) ? ALU_ADD : ALU_XOR;
            alu_src_sel = 1'b1;
            state_d     = WB;
          end
          CMD_LW, CMD_SW: begin
            alui_sel    = ALU_ADD;
            alu_src_sel = 1'b1;
            state_d     = MEM;
          end
          CMD_BEQ, CMD_BNE: begin
            // pc_write is qualified by the zero flag inside the datapath.
            branch   = 1'b1;
            alu_sel  = ALU_SUB;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
          end
          CMD_J: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
          end
          CMD_JR: begin
            jump     = 1'b1;
            jr_sel   = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
          end
          CMD_JAL: begin
            jump         = 1'b1;
            jal_sel_addr = 1'b1;
            pc_write     = 1'b1;
            state_d      = WB;
          end
          default: state_d = FETCH;
        endcase
      end

      MEM: begin
        dmem_read = (cmd_q == CMD_LW);
        mem_write = (cmd_q == CMD_SW);
        if (wait_hit) begin
          dmem_read   = 1'b0;
          mem_write   = 1'b0;
          set_timeout = 1'b1;
          state_d     = FETCH;
        end else if (dmem_ready) begin
          if (cmd_q == CMD_LW) begin
            state_d = WB;
          end else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
      end

      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cmd_q == CMD_LW);
        jal_sel_d  = (cmd_q == CMD_JAL);
        retire     = 1'b1;
        state_d    = FETCH;
      end

      default: state_d = FETCH;
    endcase

    // Stall or reset: hold position and suppress every enable and event.
    if (!go) begin
      state_d     = state_q;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      imem_read   = 1'b0;
      dmem_read   = 1'b0;
      retire      = 1'b0;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
    end
  end

endmodule
